// File: rtl/fp_add_seq_ctrl.sv
// fp_add_seq_ctrl: multi-cycle single-precision adder sequencer.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a/b operand
// handshake, out_valid/out_ready/result packed-sum handshake.
// Truncating rounding; denormal inputs are flushed to zero.

module barrelshift_right (
    input  logic [23:0] i_data,
    input  logic [4:0]  i_sm,
    output logic [23:0] o_data
);
    assign o_data = i_data >> i_sm;
endmodule

module barrelshift_left (
    input  logic [24:0] i_data,
    input  logic [4:0]  i_sm,
    output logic [24:0] o_data
);
    assign o_data = i_data << i_sm;
endmodule

module fp_add_seq_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b, r_result;
    logic        r_sx, r_sub;
    logic [7:0]  r_ex;
    logic [23:0] r_mx, r_my;
    logic [24:0] r_sum;

    logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
    logic [22:0] w_fa, w_fb;
    logic [23:0] w_ma, w_mb, w_mx, w_my, w_my_sh, w_my_al;
    logic        w_swap, w_sx, w_sy;
    logic [4:0]  w_lz, w_sm;
    logic [24:0] w_nsh;
    logic signed [9:0] w_exp_n;
    logic [22:0] w_frac_n;
    logic        w_zero;
    logic [31:0] w_packed;

    // Unpack with flush-to-zero, then order by magnitude.
    assign w_ea = r_a[30:23];
    assign w_eb = r_b[30:23];
    assign w_fa = (w_ea != 8'd0) ? r_a[22:0] : 23'd0;
    assign w_fb = (w_eb != 8'd0) ? r_b[22:0] : 23'd0;
    assign w_ma = {w_ea != 8'd0, w_fa};
    assign w_mb = {w_eb != 8'd0, w_fb};
    assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_ex = w_swap ? w_eb : w_ea;
    assign w_ey = w_swap ? w_ea : w_eb;
    assign w_mx = w_swap ? w_mb : w_ma;
    assign w_my = w_swap ? w_ma : w_mb;
    assign w_sx = w_swap ? r_b[31] : r_a[31];
    assign w_sy = w_swap ? r_a[31] : r_b[31];
    assign w_d  = w_ex - w_ey;

    barrelshift_right u_rsh (
        .i_data (w_my),
        .i_sm   (w_d[4:0]),
        .o_data (w_my_sh)
    );

    assign w_my_al = (w_d >= 8'd24) ? 24'd0 : w_my_sh;

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++)
            if (r_sum[i]) w_lz = 5'(23 - i);
    end

    // No shift on carry-out, so the shifter output's top two bits
    // are nonzero exactly when the sum is nonzero.
    assign w_sm = r_sum[24] ? 5'd0 : w_lz;

    barrelshift_left u_lsh (
        .i_data (r_sum),
        .i_sm   (w_sm),
        .o_data (w_nsh)
    );

    assign w_zero = ~(w_nsh[24] | w_nsh[23]);
    assign w_frac_n = r_sum[24] ? w_nsh[23:1] : w_nsh[22:0];
    assign w_exp_n = r_sum[24]
        ? $signed({2'b00, r_ex}) + 10'sd1
        : $signed({2'b00, r_ex}) - $signed({5'b00000, w_lz});

    always_comb begin
        w_packed = {r_sx, w_exp_n[7:0], w_frac_n};
        if (w_zero)
            w_packed = 32'h0;
        else if (w_exp_n <= 10'sd0)
            w_packed = {r_sx, 31'h0};
        else if (w_exp_n >= 10'sd255)
            w_packed = {r_sx, 8'hFF, 23'h0};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_sx     <= 1'b0;
            r_sub    <= 1'b0;
            r_ex     <= 8'h0;
            r_mx     <= 24'h0;
            r_my     <= 24'h0;
            r_sum    <= 25'h0;
            r_result <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_ALIGN: begin
                    r_sx  <= w_sx;
                    r_sub <= w_sx ^ w_sy;
                    r_ex  <= w_ex;
                    r_mx  <= w_mx;
                    r_my  <= w_my_al;
                end
                S_ADD: begin
                    if (r_sub) r_sum <= {1'b0, r_mx} - {1'b0, r_my};
                    else       r_sum <= {1'b0, r_mx} + {1'b0, r_my};
                end
                S_NORM: r_result <= w_packed;
                default: ;
            endcase
        end
    end

    assign result = r_result;
endmodule
